// File: rtl/uart_rx_if.sv
// Byte-side bundle of the UART receiver: received data, its handshake and the sticky error flags.
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  modport master (output data, output valid, output frame_err, output overrun, input ready);
  modport slave  (input data, input valid, input frame_err, input overrun, output ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver; valid rises ~2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start edge.
// One-byte holding register: a byte arriving while valid&!ready is dropped and flags overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus
);

  localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_m, rx_s;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             stop_hit;
  logic             accept, load, drop, ferr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    stop_hit  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Mid start bit: a high line here was a glitch, drop it silently.
        if (cnt == HALF_TC) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_TC) begin
          cnt_nxt   = '0;
          shreg_nxt = {rx_s, shreg[7:1]};
          bit_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leave at mid stop bit so a following start edge is never missed.
        if (cnt == FULL_TC) begin
          cnt_nxt   = '0;
          stop_hit  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = bus.valid & bus.ready;
  assign load   = stop_hit &  rx_s & (~bus.valid | bus.ready);
  assign drop   = stop_hit &  rx_s &  bus.valid & ~bus.ready;
  assign ferr   = stop_hit & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data      <= 8'h00;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (load) begin
        bus.data  <= shreg;
        bus.valid <= 1'b1;
      end else if (accept) begin
        bus.valid <= 1'b0;
      end
      // Setting a flag wins over the clear from a same-edge handshake.
      if (ferr)        bus.frame_err <= 1'b1;
      else if (accept) bus.frame_err <= 1'b0;
      if (drop)        bus.overrun   <= 1'b1;
      else if (accept) bus.overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx with a frame-level reference model of the byte interface.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk;
  logic rst;
  logic rx;
  logic ready_r;

  uart_rx_if bus ();
  assign bus.ready = ready_r;

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: consumed bytes, valid-high cycle count, valid rise time.
  logic       mon_en = 1'b0;
  logic       prev_v = 1'b0;
  int         vld_cnt = 0;
  int         t_vld = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (mon_en && bus.valid && bus.ready) got_q.push_back(bus.data);
    if (bus.valid) vld_cnt++;
    if (bus.valid && !prev_v) t_vld = cyc;
    prev_v = bus.valid;
  end

  // Reference model: state of the holding register after each whole frame.
  logic       m_valid, m_ferr, m_ovr;
  logic [7:0] m_data;
  logic [7:0] exp_q[$];
  int         t_start;

  task automatic model_reset();
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    m_data  = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok) begin
      m_ferr = 1'b1;
    end else if (ready_r) begin
      exp_q.push_back(b);
      m_data = b;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string step);
    chk({step, ".valid"},     32'(bus.valid),     32'(m_valid));
    chk({step, ".data"},      32'(bus.data),      32'(m_data));
    chk({step, ".frame_err"}, 32'(bus.frame_err), 32'(m_ferr));
    chk({step, ".overrun"},   32'(bus.overrun),   32'(m_ovr));
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // A bad stop bit is held low long enough to be sampled, then released.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (CPB - 12) @(negedge clk);
    end
    model_frame(b, stop_ok);
  endtask

  task automatic pulse_ready();
    ready_r = 1'b1;
    @(negedge clk);
    ready_r = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  task automatic do_reset(input string step);
    rx      = 1'b1;
    ready_r = 1'b0;
    rst     = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_model(step);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    int         v0, lat;

    rx = 1'b1;
    ready_r = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset("reset");

    // 1: single byte held, then consumed
    send_frame(8'hA5, 1'b1);
    check_model("t1_rx");
    lat = t_vld - t_start;
    chk("t1_latency_in_window", 32'(lat >= 153 && lat <= 155), 32'd1);
    pulse_ready();
    check_model("t1_ack");

    // 2: back-to-back with ready tied high
    exp_q.delete();
    ready_r = 1'b1;
    mon_en  = 1'b1;
    v0 = vld_cnt;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1);
    repeat (4) @(negedge clk);
    mon_en  = 1'b0;
    ready_r = 1'b0;
    chk("t2_count", 32'(got_q.size()), 32'(exp_q.size()));
    chk("t2_valid_cycles", 32'(vld_cnt - v0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk($sformatf("t2_byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_model("t2_end");

    // 3: overrun
    send_frame(8'h11, 1'b1);
    send_frame(8'($urandom_range(0, 255)) | 8'h22, 1'b1);
    check_model("t3_ovr");
    pulse_ready();
    check_model("t3_ack");

    // 4: bad stop then a long break
    v0 = vld_cnt;
    send_frame(8'h55, 1'b0);
    check_model("t4_ferr");
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    check_model("t4_break");
    chk("t4_no_valid", 32'(vld_cnt - v0), 32'd0);
    do_reset("t4_reset");

    // 5: short glitch, then a clean byte
    v0 = vld_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_model("t5_glitch");
    chk("t5_no_valid", 32'(vld_cnt - v0), 32'd0);
    send_frame(8'h7E, 1'b1);
    check_model("t5_rx");

    // 6: asynchronous reset during data bit 4, with a byte still held
    send_bit(1'b0);
    b = 8'hC3;
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    rx = b[4];
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1 check_model("t6_async");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'hC3, 1'b1);
    check_model("t6_rx");
    pulse_ready();

    // Randomized frames with random consumption
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(b, s);
      check_model($sformatf("rnd%0d_rx", i));
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready();
        check_model($sformatf("rnd%0d_ack", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
